// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses around the memory arbiter:
//   fetch port  : i_req, i_addr            -> i_gnt, i_rvalid, i_rdata
//   data port   : d_req, d_we, d_wmask,
//                 d_addr, d_wdata          -> d_gnt, d_rvalid, d_rdata
//   RAM port    : mem_en, mem_we, mem_addr,
//                 mem_wdata                <- mem_rdata
//
// Handshake: a requester raises *_req with its address/data stable and keeps
// them stable until it sees *_gnt high in the same cycle; the access is
// accepted on that clock edge. Dropping *_req before a grant withdraws the
// request. Reads return exactly one cycle after the grant as a one-cycle
// *_rvalid pulse; there is no back-pressure on read data.
//
// Modports:
//   slave  : arbiter view (takes requests, drives grants and the RAM port)
//   master : environment view (requesters plus the RAM model)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 8
);
    // fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    // data port
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_wmask;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    // single-port RAM
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_wmask, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_wmask, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port 32-bit RAM between an instruction-fetch port and a
// load/store port. One access per cycle; data normally has priority, but a
// fetch that has lost STARVE_LIMIT consecutive cycles wins the next one.
//
// Ports:
//   CLK        : clock, all state on the rising edge
//   RESET      : asynchronous active-low reset
//   bus        : mem_arbiter_if.slave (fetch, data and RAM buses)
//   starve_cnt : debug view of the fetch starvation counter
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                              CLK,
    input  logic                              RESET,
    mem_arbiter_if.slave                      bus,
    output logic [$clog2(STARVE_LIMIT+1)-1:0] starve_cnt
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // registered state
    logic [CNT_W-1:0] starve_q;
    logic             rd_valid_q;   // a read was granted last cycle
    logic             rd_tag_q;     // owner of that read: 1 = data, 0 = fetch
    logic [31:0]      i_rdata_q;    // last delivered fetch word
    logic [31:0]      d_rdata_q;    // last delivered load word

    // combinational decisions
    logic             fetch_wins;
    logic             i_gnt_c;
    logic             d_gnt_c;
    logic [CNT_W-1:0] starve_d;

    // -----------------------------------------------------------------------
    // Arbitration. Grants are forced low while RESET is asserted so nothing
    // reaches the RAM during reset.
    // -----------------------------------------------------------------------
    always_comb begin
        fetch_wins = bus.i_req && (!bus.d_req || (starve_q == LIMIT));
        i_gnt_c    = RESET && fetch_wins;
        d_gnt_c    = RESET && bus.d_req && !fetch_wins;
    end

    // -----------------------------------------------------------------------
    // RAM port drive. mem_addr follows the fetch address when idle; it is
    // only meaningful while mem_en is high.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.i_gnt     = i_gnt_c;
        bus.d_gnt     = d_gnt_c;
        bus.mem_en    = i_gnt_c || d_gnt_c;
        bus.mem_we    = 4'b0000;
        bus.mem_wdata = 32'h0;
        bus.mem_addr  = bus.i_addr;
        if (d_gnt_c) begin
            bus.mem_addr = bus.d_addr;
            if (bus.d_we) begin
                // a zero mask still occupies the RAM cycle, it just writes nothing
                bus.mem_we    = bus.d_wmask;
                bus.mem_wdata = bus.d_wdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Starvation counter: counts cycles a pending fetch loses to data and
    // saturates at the limit; any fetch grant or idle fetch port clears it.
    // -----------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (!bus.i_req || i_gnt_c) begin
            starve_d = '0;
        end else if (d_gnt_c && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign starve_cnt = starve_q;

    // -----------------------------------------------------------------------
    // Read return tracking. Only loads and fetches set rd_valid; stores do
    // not, so they never produce an rvalid. Reset clears the tag, which
    // cancels any read in flight.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_valid_q <= 1'b0;
            rd_tag_q   <= 1'b0;
        end else begin
            rd_valid_q <= i_gnt_c || (d_gnt_c && !bus.d_we);
            rd_tag_q   <= d_gnt_c;
        end
    end

    always_comb begin
        bus.i_rvalid = rd_valid_q && !rd_tag_q;
        bus.d_rvalid = rd_valid_q && rd_tag_q;
    end

    // -----------------------------------------------------------------------
    // Read data: the RAM word passes straight through during the rvalid
    // cycle and is captured so the port holds it afterwards.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            if (bus.i_rvalid) begin
                i_rdata_q <= bus.mem_rdata;
            end
            if (bus.d_rvalid) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.i_rdata = bus.i_rvalid ? bus.mem_rdata : i_rdata_q;
        bus.d_rdata = bus.d_rvalid ? bus.mem_rdata : d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural single-port RAM.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int ADDR_W       = 8;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = $clog2(STARVE_LIMIT + 1);

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] starve_cnt;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .bus       (bus),
        .starve_cnt(starve_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [31:0] ram [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we == 4'b0000) begin
                bus.mem_rdata <= ram[bus.mem_addr];
            end
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          total;
    int          bad;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_wmask = 4'b0000;
        bus.d_addr  = '0;
        bus.d_wdata = 32'h0;
    endtask

    task automatic drive_load(input logic [ADDR_W-1:0] addr);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = addr;
    endtask

    task automatic drive_store(input logic [ADDR_W-1:0] addr, input logic [3:0] mask,
                               input logic [31:0] data);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = addr;
        bus.d_wmask = mask;
        bus.d_wdata = data;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad   = 0;
        bus.mem_rdata = 32'h0;
        for (int k = 0; k < (1 << ADDR_W); k++) ram[k] = 32'hA500_0000 | k;
        ram[0] = 32'h1111_1111;
        ram[1] = 32'h2222_2222;
        ram[2] = 32'h3333_3333;
        ram[3] = 32'h0000_0000;
        ram[5] = 32'h0010_0093;

        // reset with both requests high: nothing may be granted
        idle_inputs();
        rst_n     = 1'b0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        #12;
        check("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
        check("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
        check("rst_i_rdata", bus.i_rdata, 32'h0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        check("rst_starve", 32'(starve_cnt), 32'd0);

        // release and fetch in the very first cycle out of reset
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();
        bus.i_req  = 1'b1;
        bus.i_addr = 8'd5;
        settle();
        check("fetch_i_gnt", 32'(bus.i_gnt), 32'd1);
        check("fetch_mem_en", 32'(bus.mem_en), 32'd1);
        check("fetch_mem_addr", 32'(bus.mem_addr), 32'd5);
        check("fetch_mem_we", 32'(bus.mem_we), 32'd0);
        next_cycle();
        idle_inputs();
        settle();
        check("fetch_i_rvalid", 32'(bus.i_rvalid), 32'd1);
        check("fetch_i_rdata", bus.i_rdata, 32'h0010_0093);
        check("fetch_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        next_cycle();
        settle();
        check("fetch_rvalid_drop", 32'(bus.i_rvalid), 32'd0);
        check("fetch_rdata_hold", bus.i_rdata, 32'h0010_0093);

        // starvation: both requests held high
        next_cycle();
        bus.i_req  = 1'b1;
        bus.i_addr = 8'h20;
        drive_load(8'h21);
        for (int c = 0; c < 6; c++) begin
            settle();
            check($sformatf("starve_d_gnt_%0d", c), 32'(bus.d_gnt), (c == 4) ? 32'd0 : 32'd1);
            check($sformatf("starve_i_gnt_%0d", c), 32'(bus.i_gnt), (c == 4) ? 32'd1 : 32'd0);
            check($sformatf("starve_cnt_%0d", c), 32'(starve_cnt), (c <= 4) ? 32'(c) : 32'd0);
            check($sformatf("starve_addr_%0d", c), 32'(bus.mem_addr), (c == 4) ? 32'h20 : 32'h21);
            if (c >= 1) begin
                check($sformatf("starve_i_rv_%0d", c), 32'(bus.i_rvalid), (c == 5) ? 32'd1 : 32'd0);
                check($sformatf("starve_d_rv_%0d", c), 32'(bus.d_rvalid), (c == 5) ? 32'd0 : 32'd1);
            end
            next_cycle();
        end
        idle_inputs();
        settle();
        check("starve_last_d_rv", 32'(bus.d_rvalid), 32'd1);
        check("starve_last_d_rdata", bus.d_rdata, 32'hA500_0021);

        // partial store then load of the same word
        next_cycle();
        drive_store(8'd3, 4'b0011, 32'hAABB_CCDD);
        settle();
        check("st_d_gnt", 32'(bus.d_gnt), 32'd1);
        check("st_mem_we", 32'(bus.mem_we), 32'b0011);
        check("st_mem_wdata", bus.mem_wdata, 32'hAABB_CCDD);
        check("st_mem_addr", 32'(bus.mem_addr), 32'd3);
        next_cycle();
        drive_load(8'd3);
        settle();
        check("st_no_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("ld_d_gnt", 32'(bus.d_gnt), 32'd1);
        check("ld_mem_we", 32'(bus.mem_we), 32'd0);
        next_cycle();
        idle_inputs();
        settle();
        check("ld_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        check("ld_d_rdata", bus.d_rdata, 32'h0000_CCDD);

        // store with empty mask still takes the RAM cycle
        next_cycle();
        drive_store(8'd4, 4'b0000, 32'hFFFF_FFFF);
        settle();
        check("st0_d_gnt", 32'(bus.d_gnt), 32'd1);
        check("st0_mem_en", 32'(bus.mem_en), 32'd1);
        check("st0_mem_we", 32'(bus.mem_we), 32'd0);
        next_cycle();
        idle_inputs();
        settle();
        check("st0_no_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("idle_mem_en", 32'(bus.mem_en), 32'd0);

        // back-to-back fetches at 0, 1, 2
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                bus.i_req  = 1'b1;
                bus.i_addr = ADDR_W'(k);
            end else begin
                idle_inputs();
            end
            settle();
            if (k < 3) begin
                check($sformatf("b2b_i_gnt_%0d", k), 32'(bus.i_gnt), 32'd1);
                exp_q.push_back((k == 0) ? 32'h1111_1111 : (k == 1) ? 32'h2222_2222 : 32'h3333_3333);
            end
            if (k >= 1) begin
                check($sformatf("b2b_i_rvalid_%0d", k), 32'(bus.i_rvalid), 32'd1);
                if (exp_q.size() > 0) check($sformatf("b2b_i_rdata_%0d", k), bus.i_rdata, exp_q.pop_front());
            end
            next_cycle();
        end
        settle();
        check("b2b_rvalid_end", 32'(bus.i_rvalid), 32'd0);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // reset while a load is in flight
        next_cycle();
        drive_load(8'h10);
        settle();
        check("rmr_d_gnt", 32'(bus.d_gnt), 32'd1);
        next_cycle();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("rmr_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("rmr_d_rdata", bus.d_rdata, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        settle();
        check("rmr_after_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("rmr_after_d_rdata", bus.d_rdata, 32'h0);
        next_cycle();
        settle();
        check("rmr_late_d_rvalid", 32'(bus.d_rvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog: the directed sequence is short, so this only trips on a hang
    initial begin
        #20000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width (256 x 32-bit words).
REQ-002 Parameter STARVE_LIMIT, default 4, maximum consecutive cycles a pending fetch may lose arbitration to data.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  instruction-fetch request; held with i_addr stable until i_gnt.
REQ-006 i_addr  input  ADDR_W  fetch word address.
REQ-007 i_gnt  output  1  fetch accepted this cycle.
REQ-008 i_rvalid  output  1  i_rdata valid (one-cycle pulse).
REQ-009 i_rdata  output  32  fetched word.
REQ-010 d_req  input  1  load/store request; held with d_we, d_wmask, d_addr, d_wdata stable until d_gnt.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_wmask  input  4  store byte enables; bit n enables bits [8n+7:8n].
REQ-013 d_addr  input  ADDR_W  data word address.
REQ-014 d_wdata  input  32  store data.
REQ-015 d_gnt  output  1  data access accepted this cycle.
REQ-016 d_rvalid  output  1  d_rdata valid (one-cycle pulse, loads only).
REQ-017 d_rdata  output  32  loaded word.
REQ-018 mem_en  output  1  single-port RAM access strobe.
REQ-019 mem_we  output  4  RAM byte write enables.
REQ-020 mem_addr  output  ADDR_W  RAM word address.
REQ-021 mem_wdata  output  32  RAM write data.
REQ-022 mem_rdata  input  32  RAM read data, valid exactly one cycle after mem_en with mem_we = 0.

Function
REQ-023 Grants, mem_en, mem_we, mem_addr, and mem_wdata are combinational from requests and registered state; at most one of i_gnt and d_gnt is high per cycle.
REQ-024 When only one request is high, that requester is granted the same cycle.
REQ-025 When both are high, data wins unless starve_cnt == STARVE_LIMIT, in which case the fetch wins.
REQ-026 starve_cnt: increments (saturating at STARVE_LIMIT) each cycle i_req is high and d_gnt is high; clears to 0 when i_gnt is high or i_req is low.
REQ-027 On grant: mem_en = 1 and mem_addr = the granted address; for a data store, mem_we = d_wmask and mem_wdata = d_wdata; otherwise mem_we = 0.
REQ-028 When no grant is made: mem_en = 0, mem_we = 0.
REQ-029 Read response: a one-bit registered tag records the granted read owner; the next cycle raises that owner's rvalid and drives its rdata = mem_rdata.
REQ-030 rdata holds its last value while rvalid is low.
REQ-031 Stores produce no rvalid.
REQ-032 A store with d_wmask = 0 is still granted and consumes the cycle, with mem_we = 0000.
REQ-033 Throughput: one access per cycle; a new grant may coincide with the previous access's rvalid.
REQ-034 Requests are not queued; the requester keeps req high until it sees gnt, and a req dropped before grant is discarded.

Reset
REQ-035 While RESET = 0: i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en = 0; mem_we = 0000; starve_cnt = 0; i_rdata, d_rdata = 0; read tag cleared.
REQ-036 Reset asserted with a read in flight cancels it; no rvalid follows after RESET returns high.
REQ-037 The first grant is possible in the first cycle with RESET = 1.

Verification
REQ-038 Reset case: RESET = 0, i_req = d_req = 1 -> all grants, rvalids, and mem_en are 0; mem_we = 0000.
REQ-039 Fetch case: i_req = 1, i_addr = 5, RAM[5] = 0x00100093 -> i_gnt and mem_en high in cycle N with mem_addr = 5; i_rvalid high in N+1 with i_rdata = 0x00100093.
REQ-040 Starvation case: i_req and d_req held high continuously, STARVE_LIMIT = 4 -> d_gnt in cycles 0-3, i_gnt in cycle 4, d_gnt again in cycle 5; starve_cnt is 0 after cycle 4.
REQ-041 Store case: d_we = 1, d_wmask = 0011, d_addr = 3, d_wdata = 0xAABBCCDD over RAM[3] = 0 -> mem_we = 0011, no d_rvalid; a following load of address 3 returns 0x0000CCDD.
REQ-042 Reset mid-read: d_req load granted in cycle N, RESET = 0 during N+1 -> d_rvalid stays 0 and d_rdata = 0.
REQ-043 Back-to-back: fetches at addresses 0, 1, 2 on consecutive cycles -> three consecutive i_rvalid pulses with data in order.
